// File: rtl/aes_mimo_stream.sv
`default_nettype none
// ============================================================================
// Module   : aes_mimo_stream
// Brief    : N-lane lock-step AES-128 batch engine with a valid/ready input
//            and a batch-wide output FIFO.
// Revision : 1.0
// ============================================================================

module aes_mimo_stream_cntx (
    input  logic       clk,
    input  logic       rstn,
    input  logic       start,
    output logic       round_en,
    output logic       last_round,
    output logic [7:0] rcon,
    output logic       done
);
    logic       r_running;
    logic [3:0] r_round;
    logic [7:0] r_rcon;
    logic       r_done;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_running <= 1'b0;
            r_round   <= 4'd0;
            r_rcon    <= 8'h00;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (start) begin
                r_running <= 1'b1;
                r_round   <= 4'd1;
                r_rcon    <= 8'h01;
            end else if (r_running) begin
                if (r_round == 4'd10) begin
                    r_running <= 1'b0;
                    r_done    <= 1'b1;
                end
                r_round <= r_round + 4'd1;
                r_rcon  <= {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);
            end
        end
    end

    assign round_en   = r_running;
    assign last_round = (r_round == 4'd10);
    assign rcon       = r_rcon;
    assign done       = r_done;
endmodule

module aes_mimo_stream_core (
    input  logic         clk,
    input  logic         rstn,
    input  logic         start,
    input  logic         round_en,
    input  logic         last_round,
    input  logic [7:0]   rcon,
    input  logic [127:0] plain,
    input  logic [127:0] key,
    output logic [127:0] cipher
);
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // S-box as GF(2^8) inverse (x^254) followed by the affine map
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] y;
        logic [7:0] inv;
        y   = gf_mul(x, x);
        inv = y;
        for (int i = 0; i < 6; i++) begin
            y   = gf_mul(y, y);
            inv = gf_mul(inv, y);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    logic [127:0] r_state;
    logic [127:0] r_rk;
    logic [31:0]  w_kt;
    logic [127:0] w_nk;
    logic [127:0] w_sr;
    logic [127:0] w_mix;
    logic [127:0] w_next;

    always_comb begin
        w_kt = {sbox(r_rk[23:16]), sbox(r_rk[15:8]), sbox(r_rk[7:0]), sbox(r_rk[31:24])}
               ^ {rcon, 24'h000000};
        w_nk[127:96] = r_rk[127:96] ^ w_kt;
        w_nk[95:64]  = r_rk[95:64]  ^ w_nk[127:96];
        w_nk[63:32]  = r_rk[63:32]  ^ w_nk[95:64];
        w_nk[31:0]   = r_rk[31:0]   ^ w_nk[63:32];
        w_sr  = '0;
        w_mix = '0;
        // Byte (row r, column c) sits at index 4c+r, most significant first
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                w_sr[127-8*(4*c+r) -: 8] = sbox(r_state[127-8*(4*((c+r)%4)+r) -: 8]);
            end
        end
        for (int c = 0; c < 4; c++) begin
            w_mix[127-32*c -: 32] = mix_col(w_sr[127-32*c -: 32]);
        end
        w_next = (last_round ? w_sr : w_mix) ^ w_nk;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= '0;
            r_rk    <= '0;
        end else if (start) begin
            r_state <= plain ^ key;
            r_rk    <= key;
        end else if (round_en) begin
            r_state <= w_next;
            r_rk    <= w_nk;
        end
    end

    assign cipher = r_state;
endmodule

module aes_mimo_stream #(
    parameter int N         = 4,
    parameter int OUT_DEPTH = 2,
    parameter int TAG_W     = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N-1:0]       in_mask,
    input  logic [128*N-1:0]   in_plain,
    input  logic [128*N-1:0]   in_key,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [128*N-1:0]   out_cipher,
    output logic [N-1:0]       out_mask,
    output logic [TAG_W-1:0]   out_tag,
    output logic               busy,
    output logic [15:0]        batch_count
);
    localparam int PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int CNT_W = $clog2(OUT_DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_START   = 2'd1,
        S_RUN     = 2'd2,
        S_CAPTURE = 2'd3
    } state_t;

    state_t               r_state, w_state_n;
    logic                 w_cntx_start;
    logic                 w_rstn;
    logic                 w_round_en, w_last_round, w_done;
    logic [7:0]           w_rcon;
    logic [128*N-1:0]     r_plain, r_key;
    logic [N-1:0]         r_mask;
    logic [TAG_W-1:0]     r_tag, r_batch_tag;
    logic [15:0]          r_batch_count;
    logic [128*N-1:0]     w_in_expand, w_run_expand, w_cipher;
    logic [128*N-1:0]     r_fifo_cipher [OUT_DEPTH];
    logic [N-1:0]         r_fifo_mask   [OUT_DEPTH];
    logic [TAG_W-1:0]     r_fifo_tag    [OUT_DEPTH];
    logic [PTR_W-1:0]     r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0]     r_count;
    logic                 w_accept, w_push, w_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(OUT_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_rstn = ~rst;

    aes_mimo_stream_cntx u_cntx (
        .clk        (clk),
        .rstn       (w_rstn),
        .start      (w_cntx_start),
        .round_en   (w_round_en),
        .last_round (w_last_round),
        .rcon       (w_rcon),
        .done       (w_done)
    );

    for (genvar i = 0; i < N; i++) begin : g_lane
        assign w_in_expand[128*i +: 128]  = {128{in_mask[i]}};
        assign w_run_expand[128*i +: 128] = {128{r_mask[i]}};
        aes_mimo_stream_core u_core (
            .clk        (clk),
            .rstn       (w_rstn),
            .start      (w_cntx_start),
            .round_en   (w_round_en),
            .last_round (w_last_round),
            .rcon       (w_rcon),
            .plain      (r_plain[128*i +: 128]),
            .key        (r_key[128*i +: 128]),
            .cipher     (w_cipher[128*i +: 128])
        );
    end

    assign in_ready  = (r_state == S_IDLE) && (r_count < CNT_W'(OUT_DEPTH));
    assign w_accept  = in_valid & in_ready;
    assign w_push    = (r_state == S_CAPTURE);
    assign out_valid = (r_count != '0);
    assign w_pop     = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_n;
    end

    always_comb begin
        w_state_n    = r_state;
        w_cntx_start = 1'b0;
        case (r_state)
            S_IDLE:    if (w_accept) w_state_n = S_START;
            S_START: begin
                w_cntx_start = 1'b1;
                w_state_n    = S_RUN;
            end
            S_RUN:     if (w_done) w_state_n = S_CAPTURE;
            S_CAPTURE: w_state_n = S_IDLE;
            default:   w_state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_plain       <= '0;
            r_key         <= '0;
            r_mask        <= '0;
            r_tag         <= '0;
            r_batch_tag   <= '0;
            r_batch_count <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            for (int i = 0; i < OUT_DEPTH; i++) begin
                r_fifo_cipher[i] <= '0;
                r_fifo_mask[i]   <= '0;
                r_fifo_tag[i]    <= '0;
            end
        end else begin
            if (w_accept) begin
                r_plain     <= in_plain & w_in_expand;
                r_key       <= in_key & w_in_expand;
                r_mask      <= in_mask;
                r_batch_tag <= r_tag;
            end
            if (w_push) begin
                r_fifo_cipher[r_wr_ptr] <= w_cipher & w_run_expand;
                r_fifo_mask[r_wr_ptr]   <= r_mask;
                r_fifo_tag[r_wr_ptr]    <= r_batch_tag;
                r_wr_ptr                <= ptr_inc(r_wr_ptr);
                r_tag                   <= r_tag + 1'b1;
                if (r_batch_count != 16'hFFFF) r_batch_count <= r_batch_count + 16'd1;
            end
            if (w_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_push && w_pop) r_count <= r_count - 1'b1;
        end
    end

    assign out_cipher  = r_fifo_cipher[r_rd_ptr];
    assign out_mask    = r_fifo_mask[r_rd_ptr];
    assign out_tag     = r_fifo_tag[r_rd_ptr];
    assign busy        = (r_state != S_IDLE);
    assign batch_count = r_batch_count;
endmodule
`default_nettype wire
